// File: rtl/axi_vision_pkg.sv
// Shared types and helpers for the AXI4-Stream video front-end blocks.
// Holds the line_buffer_ctrl state encoding and the kernel border helper.
package axi_vision_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        START,
        ACTIVE,
        PAD,
        DROP,
        FLUSH,
        DONE
    } lbc_state_t;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned border(input int unsigned k);
        return k / 2;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Sequences line_buffer from an AXI4-Stream video input: repairs short/long lines,
// gates pushes on downstream readiness and flushes BORDER pad rows after the last line.
module line_buffer_ctrl
    import axi_vision_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH   = 1920,
    parameter int unsigned KERNEL_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      cfg_width,
    input  logic [CNT_W-1:0]      cfg_height,
    input  logic [DATA_WIDTH-1:0] cfg_pad,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    input  logic                  dn_ready,
    output logic                  lb_frame_start,
    output logic                  lb_pixel_valid,
    output logic [DATA_WIDTH-1:0] lb_pixel_data,
    output logic [CNT_W-1:0]      lb_img_width,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_sof,
    output logic                  err_cfg
);

    localparam logic [CNT_W-1:0] BORDER = CNT_W'(border(KERNEL_SIZE));
    localparam logic [CNT_W-1:0] K_MIN  = CNT_W'(KERNEL_SIZE);
    localparam logic [CNT_W-1:0] W_MAX  = CNT_W'(IMG_WIDTH);

    lbc_state_t            state_q, state_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      flush_q, flush_d;
    logic [CNT_W-1:0]      width_q, width_d;
    logic [CNT_W-1:0]      height_q, height_d;
    logic [DATA_WIDTH-1:0] pad_q, pad_d;

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  fs_d, fd_d;
    logic                  err_short_d, err_long_d, err_sof_d, err_cfg_d;

    logic cfg_bad, col_last, row_last, flush_last, mid_sof;

    assign cfg_bad    = (cfg_width < K_MIN) || (cfg_width > W_MAX) || (cfg_height < K_MIN);
    assign col_last   = (col_q == width_q - 16'd1);
    assign row_last   = (row_q == height_q - 16'd1);
    assign flush_last = (flush_q == BORDER * width_q - 16'd1);
    // SOF is only legal on the very first pixel of a frame.
    assign mid_sof    = s_tuser && ((col_q != '0) || (row_q != '0));

    assign lb_img_width = width_q;
    assign busy         = (state_q != IDLE) && (state_q != WAIT_SOF);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        flush_d     = flush_q;
        width_d     = width_q;
        height_d    = height_q;
        pad_d       = pad_q;
        s_tready    = 1'b0;
        push        = 1'b0;
        push_data   = s_tdata;
        fs_d        = 1'b0;
        fd_d        = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_sof_d   = 1'b0;
        err_cfg_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                // SOF beat is held for START unless the config is rejected.
                s_tready = !s_tuser || (enable && cfg_bad);
                if (!enable) begin
                    state_d = IDLE;
                end else if (s_tvalid && s_tuser) begin
                    if (cfg_bad) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        pad_d    = cfg_pad;
                        state_d  = START;
                    end
                end
            end
            START: begin
                fs_d    = 1'b1;
                col_d   = '0;
                row_d   = '0;
                flush_d = '0;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                s_tready = dn_ready && !mid_sof;
                if (s_tvalid && mid_sof) begin
                    err_sof_d = 1'b1;
                    state_d   = START;
                end else if (s_tvalid && dn_ready) begin
                    push = 1'b1;
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                        if (!s_tlast) begin
                            err_long_d = 1'b1;
                            state_d    = DROP;
                        end else if (row_last) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                        if (s_tlast) begin
                            err_short_d = 1'b1;
                            state_d     = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (dn_ready) begin
                    push      = 1'b1;
                    push_data = pad_q;
                    if (col_last) begin
                        col_d   = '0;
                        row_d   = row_q + 16'd1;
                        state_d = row_last ? FLUSH : ACTIVE;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            DROP: begin
                s_tready = !s_tuser;
                if (s_tvalid && s_tuser) begin
                    err_sof_d = 1'b1;
                    state_d   = START;
                end else if (s_tvalid && s_tlast) begin
                    // row already advanced past the truncated line
                    state_d = (row_q == height_q) ? FLUSH : ACTIVE;
                end
            end
            FLUSH: begin
                if (dn_ready) begin
                    push      = 1'b1;
                    push_data = pad_q;
                    if (flush_last) begin
                        flush_d = '0;
                        state_d = DONE;
                    end else begin
                        flush_d = flush_q + 16'd1;
                    end
                end
            end
            DONE: begin
                fd_d    = 1'b1;
                state_d = WAIT_SOF;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            flush_q        <= '0;
            width_q        <= '0;
            height_q       <= '0;
            pad_q          <= '0;
            lb_frame_start <= 1'b0;
            lb_pixel_valid <= 1'b0;
            lb_pixel_data  <= '0;
            frame_done     <= 1'b0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
            err_sof        <= 1'b0;
            err_cfg        <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            flush_q        <= flush_d;
            width_q        <= width_d;
            height_q       <= height_d;
            pad_q          <= pad_d;
            lb_frame_start <= fs_d;
            lb_pixel_valid <= push;
            if (push) lb_pixel_data <= push_data;
            frame_done     <= fd_d;
            err_short      <= err_short_d;
            err_long       <= err_long_d;
            err_sof        <= err_sof_d;
            err_cfg        <= err_cfg_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: nominal, short/long lines, backpressure,
// mid-frame SOF, bad config and mid-frame reset.
module tb_line_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] cfg_width, cfg_height;
    logic [7:0]  cfg_pad;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [7:0]  s_tdata;
    logic        dn_ready = 1'b1;
    logic        lb_frame_start, lb_pixel_valid;
    logic [7:0]  lb_pixel_data;
    logic [15:0] lb_img_width;
    logic        busy, frame_done, err_short, err_long, err_sof, err_cfg;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int fs_cnt = 0, fd_cnt = 0, es_cnt = 0, el_cnt = 0, eo_cnt = 0, ec_cnt = 0;
    int overlap = 0, bp_viol = 0, tr_viol = 0, tr_hi = 0;
    logic dn_prev = 1'b1;
    logic bp_mode = 1'b0;

    line_buffer_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_pad        (cfg_pad),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tuser        (s_tuser),
        .s_tlast        (s_tlast),
        .dn_ready       (dn_ready),
        .lb_frame_start (lb_frame_start),
        .lb_pixel_valid (lb_pixel_valid),
        .lb_pixel_data  (lb_pixel_data),
        .lb_img_width   (lb_img_width),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_sof        (err_sof),
        .err_cfg        (err_cfg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        dn_ready = bp_mode ? ~dn_ready : 1'b1;
    end

    // Observe registered outputs on the falling edge, one sample per cycle.
    always @(negedge clk) begin
        if (lb_pixel_valid) got.push_back(lb_pixel_data);
        if (lb_frame_start) fs_cnt++;
        if (frame_done) fd_cnt++;
        if (err_short) es_cnt++;
        if (err_long) el_cnt++;
        if (err_sof) eo_cnt++;
        if (err_cfg) ec_cnt++;
        if (lb_frame_start && lb_pixel_valid) overlap++;
        if (lb_pixel_valid && !dn_prev) bp_viol++;
        if (bp_mode && busy && s_tready && !dn_ready) tr_viol++;
        if (bp_mode && busy && s_tready) tr_hi++;
        dn_prev = dn_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int tag, input int r, input int c);
        return {tag[1:0], r[1:0], c[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        bit ok;
        int n;
        s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        tests_run++;
        assert (ok) else begin
            tests_failed++;
            $error("FAIL send_handshake observed=%0d expected=1 data=%0h", ok, d);
        end
    endtask

    task automatic send_line(input int tag, input int r, input int n, input bit sof);
        for (int c = 0; c < n; c++) send(pix(tag, r, c), sof && (c == 0), c == n - 1);
    endtask

    task automatic exp_line(input int tag, input int r, input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(pix(tag, r, c));
    endtask

    task automatic exp_pad(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'hA5);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (fd_cnt < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int base);
        int mism = 0;
        check({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= got.size() || got[base + i] !== exp_q[i]) mism++;
        check({tag, "_data"}, 32'(mism), 32'd0);
    endtask

    int b_p, b_fs, b_fd, b_es, b_el, b_eo, b_ec;

    task automatic snap();
        b_p = got.size(); b_fs = fs_cnt; b_fd = fd_cnt;
        b_es = es_cnt; b_el = el_cnt; b_eo = eo_cnt; b_ec = ec_cnt;
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        cfg_width = 16'd8; cfg_height = 16'd4; cfg_pad = 8'hA5;
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {23'd0, lb_frame_start, lb_pixel_valid, s_tready, busy, frame_done,
              err_short, err_long, err_sof, err_cfg}, 32'd0);
        check("reset_data", {8'd0, lb_pixel_data, lb_img_width}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;

        // 1: nominal 8x4 frame
        snap();
        for (int r = 0; r < 4; r++) begin send_line(1, r, 8, r == 0); exp_line(1, r, 8); end
        exp_pad(8);
        wait_done(b_fd + 1);
        check("t1_frame_start", 32'(fs_cnt - b_fs), 32'd1);
        check_stream("t1", b_p);
        check("t1_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        check("t1_errors", 32'(es_cnt + el_cnt + eo_cnt + ec_cnt), 32'd0);
        check("t1_img_width", {16'd0, lb_img_width}, 32'd8);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // 2: row 1 ends at col 5 -> two pad pixels
        snap();
        send_line(2, 0, 8, 1'b1); exp_line(2, 0, 8);
        send_line(2, 1, 6, 1'b0); exp_line(2, 1, 6); exp_pad(2);
        send_line(2, 2, 8, 1'b0); exp_line(2, 2, 8);
        send_line(2, 3, 8, 1'b0); exp_line(2, 3, 8);
        exp_pad(8);
        wait_done(b_fd + 1);
        check("t2_err_short", 32'(es_cnt - b_es), 32'd1);
        check_stream("t2", b_p);
        check("t2_frame_done", 32'(fd_cnt - b_fd), 32'd1);

        // 3: row 2 has 11 beats -> last 3 dropped
        snap();
        send_line(3, 0, 8, 1'b1); exp_line(3, 0, 8);
        send_line(3, 1, 8, 1'b0); exp_line(3, 1, 8);
        send_line(3, 2, 11, 1'b0); exp_line(3, 2, 8);
        send_line(3, 3, 8, 1'b0); exp_line(3, 3, 8);
        exp_pad(8);
        wait_done(b_fd + 1);
        check("t3_err_long", 32'(el_cnt - b_el), 32'd1);
        check("t3_err_short", 32'(es_cnt - b_es), 32'd0);
        check_stream("t3", b_p);

        // 4: dn_ready toggling every cycle
        snap();
        bp_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin send_line(0, r, 8, r == 0); exp_line(0, r, 8); end
        exp_pad(8);
        wait_done(b_fd + 1);
        bp_mode = 1'b0;
        check_stream("t4", b_p);
        check("t4_push_without_ready", 32'(bp_viol), 32'd0);
        check("t4_tready_without_ready", 32'(tr_viol), 32'd0);
        check("t4_tready_seen", {31'd0, tr_hi > 0}, 32'd1);
        check("t4_frame_done", 32'(fd_cnt - b_fd), 32'd1);

        // 5: SOF at row 2 col 3 restarts with a fresh frame
        snap();
        send_line(1, 0, 8, 1'b1); exp_line(1, 0, 8);
        send_line(1, 1, 8, 1'b0); exp_line(1, 1, 8);
        for (int c = 0; c < 3; c++) send(pix(1, 2, c), 1'b0, 1'b0);
        exp_line(1, 2, 3);
        for (int r = 0; r < 4; r++) begin send_line(2, r, 8, r == 0); exp_line(2, r, 8); end
        exp_pad(8);
        wait_done(b_fd + 1);
        check("t5_err_sof", 32'(eo_cnt - b_eo), 32'd1);
        check("t5_frame_start", 32'(fs_cnt - b_fs), 32'd2);
        check_stream("t5", b_p);
        check("t5_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        check("t5_overlap", 32'(overlap), 32'd0);

        // 6a: width 2 is rejected
        snap();
        cfg_width = 16'd2;
        send(8'h11, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_err_cfg", 32'(ec_cnt - b_ec), 32'd1);
        check("t6_no_frame_start", 32'(fs_cnt - b_fs), 32'd0);
        check("t6_not_busy", {31'd0, busy}, 32'd0);

        // 6b: reset at row 1 col 4
        snap();
        cfg_width = 16'd8;
        send_line(1, 0, 8, 1'b1);
        for (int c = 0; c < 4; c++) send(pix(1, 1, c), 1'b0, 1'b0);
        check("t6_busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_ctl", {23'd0, lb_frame_start, lb_pixel_valid, s_tready, busy,
              frame_done, err_short, err_long, err_sof, err_cfg}, 32'd0);
        check("t6_reset_data", {8'd0, lb_pixel_data, lb_img_width}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_frame_done", 32'(fd_cnt - b_fd), 32'd0);
        check("t6_idle_after", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
